// File: rtl/uart_rx_core.sv
// uart_rx_core: 8N1 UART receiver with a 2-flop input synchronizer, an
// oversampling bit-timing FSM and a small receive buffer with sticky
// frame/overrun error flags and a registered interrupt.
// Build option: define UART_RX_FIFO_EN for a FIFO_DEPTH-entry FIFO;
// without it, a single holding register (depth 1) is used instead.
module uart_rx_core #(
  parameter int FIFO_DEPTH = 4,
  parameter int MIN_DIV    = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        rx_i,
  input  logic [15:0] clk_div,
  input  logic        rx_en,
  input  logic        rd_en,
  input  logic        clr_err,
  output logic [7:0]  rx_data,
  output logic        rx_valid,
  output logic        frame_err,
  output logic        overrun,
  output logic        irq
);

`ifdef UART_RX_FIFO_EN
  localparam bit FIFO_EN = 1'b1;
`else
  localparam bit FIFO_EN = 1'b0;
`endif
  localparam int DEPTH = FIFO_EN ? FIFO_DEPTH : 1;
  localparam int CW    = $clog2(DEPTH) + 1;
  localparam logic [15:0] MIN_DIV_W = 16'(MIN_DIV);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP, S_BREAK} state_t;

  logic        rx_sync_p0, rx_sync_p1, rxs;
  logic [15:0] d_eff, half_d, cnt_q, cnt_d, cnt_nx;
  logic [2:0]  bit_q, bit_d;
  state_t      state_q, state_d;
  logic        shift_en, push, frame_set, pop, full, push_ok, overrun_set;
  logic [7:0]  shift_q, head;
  logic [CW-1:0] count_q;

  // ---- stage p0/p1: metastability guard on the pad input (idles high)
  // Two-flop synchronizer; reset to the idle line level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_sync_p0 <= 1'b1;
      rx_sync_p1 <= 1'b1;
    end else begin
      rx_sync_p0 <= rx_i;
      rx_sync_p1 <= rx_sync_p0;
    end
  end
  assign rxs = rx_sync_p1;

  // ---- bit timing: effective divider is clamped from below
  assign d_eff  = (clk_div < MIN_DIV_W) ? MIN_DIV_W : clk_div;
  assign half_d = d_eff >> 1;
  assign cnt_nx = cnt_q + 16'd1;

  // State register with counters for clocks-in-bit and bits-in-byte.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
    end
  end

  // Next-state logic: sample mid-start, then every d_eff clocks.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_nx;
    bit_d     = bit_q;
    shift_en  = 1'b0;
    push      = 1'b0;
    frame_set = 1'b0;
    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (!rxs) begin
          state_d = S_START;
          bit_d   = '0;
        end
      end
      S_START: begin
        if (cnt_nx >= half_d) begin
          cnt_d   = '0;
          state_d = rxs ? S_IDLE : S_DATA;
        end
      end
      S_DATA: begin
        if (cnt_nx >= d_eff) begin
          cnt_d    = '0;
          shift_en = 1'b1;
          bit_d    = bit_q + 3'd1;
          if (bit_q == 3'd7) state_d = S_STOP;
        end
      end
      S_STOP: begin
        if (cnt_nx >= d_eff) begin
          cnt_d = '0;
          if (rxs) begin
            push    = 1'b1;
            state_d = S_IDLE;
          end else begin
            frame_set = 1'b1;
            state_d   = S_BREAK;
          end
        end
      end
      S_BREAK: begin
        cnt_d = '0;
        if (rxs) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    // Disabling the receiver abandons any partial byte immediately.
    if (!rx_en) begin
      state_d   = S_IDLE;
      cnt_d     = '0;
      shift_en  = 1'b0;
      push      = 1'b0;
      frame_set = 1'b0;
    end
  end

  // Data bits arrive LSB first, so shift in from the top.
  always_ff @(posedge clk) begin
    if (shift_en) shift_q <= {rxs, shift_q[7:1]};
  end

  // ---- receive buffer: a push into a full buffer is accepted only if a pop frees a slot
  assign pop         = rd_en & rx_valid;
  assign full        = (count_q == CW'(DEPTH));
  assign push_ok     = push & (~full | pop);
  assign overrun_set = push & full & ~pop;
  assign rx_valid    = (count_q != '0);

  // Occupancy counter; the extra top bit distinguishes full from empty.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      case ({push_ok, pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

`ifdef UART_RX_FIFO_EN
  localparam int PW = $clog2(DEPTH);
  logic [7:0]    mem [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;

  // Pointers wrap naturally because the depth is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + PW'(1);
      if (pop)     rd_ptr <= rd_ptr + PW'(1);
    end
  end

  // Storage array; contents need no reset since occupancy gates the output.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= shift_q;
  end
  assign head = mem[rd_ptr];
`else
  logic [7:0] hold_q;

  // Single holding register; occupancy gates the output.
  always_ff @(posedge clk) begin
    if (push_ok) hold_q <= shift_q;
  end
  assign head = hold_q;
`endif

  assign rx_data = rx_valid ? head : 8'h00;

  // ---- status: sticky flags (a new set beats a clear) and registered irq
  // Error flags and interrupt.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_err <= 1'b0;
      overrun   <= 1'b0;
      irq       <= 1'b0;
    end else begin
      frame_err <= frame_set   | (frame_err & ~clr_err);
      overrun   <= overrun_set | (overrun & ~clr_err);
      irq       <= rx_valid | frame_err | overrun;
    end
  end

endmodule
